rv_iopmp_err_capture: RTL

//  Consumer end of the decision-logic error interface (err_transaction/err_type/err_entry_index).

---
 rtl/rv_iopmp_err_capture.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rv_iopmp_err_capture.sv
// IOPMP error capture: records the first violation from the decision logic, counts
// later ones as lost until software clears the record, and raises the IOPMP interrupt.
module rv_iopmp_err_capture #(
  parameter int SID_WIDTH      = 8,
  parameter int ADDR_WIDTH     = 64,
  parameter int LOST_CNT_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      err_transaction_i,
  input  logic [2:0]                err_type_i,
  input  logic [15:0]               err_entry_index_i,
  input  logic [SID_WIDTH-1:0]      err_sid_i,
  input  logic [ADDR_WIDTH-1:0]     err_addr_i,
  input  logic [1:0]                err_ttype_i,
  input  logic                      ie_i,
  input  logic                      clear_i,
  output logic                      err_valid_o,
  output logic [2:0]                err_type_o,
  output logic [1:0]                err_ttype_o,
  output logic [15:0]               err_eid_o,
  output logic [SID_WIDTH-1:0]      err_sid_o,
  output logic [ADDR_WIDTH-1:0]     err_addr_o,
  output logic [LOST_CNT_WIDTH-1:0] lost_cnt_o,
  output logic                      irq_o
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    CAPTURED = 1'b1
  } state_e;

  localparam logic [LOST_CNT_WIDTH-1:0] LOST_MAX = {LOST_CNT_WIDTH{1'b1}};
  localparam logic [LOST_CNT_WIDTH-1:0] LOST_ONE = {{(LOST_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                    state_r;
  state_e                    state_next_s;
  logic                      capture_s;
  logic [LOST_CNT_WIDTH-1:0] lost_next_s;
  logic                      valid_r;
  logic [2:0]                type_r;
  logic [1:0]                ttype_r;
  logic [15:0]               eid_r;
  logic [SID_WIDTH-1:0]      sid_r;
  logic [ADDR_WIDTH-1:0]     addr_r;
  logic [LOST_CNT_WIDTH-1:0] lost_cnt_r;

  // Next-state, capture enable and lost-counter update
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    lost_next_s  = lost_cnt_r;
    case (state_r)
      IDLE: begin
        if (err_transaction_i) begin
          capture_s    = 1'b1;
          state_next_s = CAPTURED;
        end else begin
          state_next_s = IDLE;
        end
      end
      CAPTURED: begin
        // A clear coinciding with a new strobe frees the record and takes the new error.
        if (clear_i && err_transaction_i) begin
          capture_s    = 1'b1;
          lost_next_s  = '0;
          state_next_s = CAPTURED;
        end else if (clear_i) begin
          lost_next_s  = '0;
          state_next_s = IDLE;
        end else if (err_transaction_i) begin
          if (lost_cnt_r != LOST_MAX) begin
            lost_next_s = lost_cnt_r + LOST_ONE;
          end else begin
            lost_next_s = lost_cnt_r;
          end
        end else begin
          lost_next_s = lost_cnt_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        lost_next_s  = '0;
      end
    endcase
  end

  // State, capture record and lost counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      valid_r    <= 1'b0;
      type_r     <= 3'd0;
      ttype_r    <= 2'd0;
      eid_r      <= 16'd0;
      sid_r      <= '0;
      addr_r     <= '0;
      lost_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      valid_r    <= (state_next_s == CAPTURED);
      lost_cnt_r <= lost_next_s;
      // Fields stay stale after a clear; software ignores them while valid is low.
      if (capture_s) begin
        type_r  <= err_type_i;
        ttype_r <= err_ttype_i;
        eid_r   <= err_entry_index_i;
        sid_r   <= err_sid_i;
        addr_r  <= err_addr_i;
      end
    end
  end

  assign err_valid_o = valid_r;
  assign err_type_o  = type_r;
  assign err_ttype_o = ttype_r;
  assign err_eid_o   = eid_r;
  assign err_sid_o   = sid_r;
  assign err_addr_o  = addr_r;
  assign lost_cnt_o  = lost_cnt_r;
  assign irq_o       = valid_r & ie_i;

endmodule
